// File: rtl/mtimer_responder.sv
// Machine timer responder: owns 64-bit mtime/mtimecmp on the data bus and
// drives the registered machine timer interrupt pending line.
module mtimer_responder #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mtip_o
);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  state_t      state;
  state_t      state_next;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] div_cnt;
  logic [31:0] rdata;
  logic        err;
  logic        mtip;

  logic        accept;
  logic        hit;
  logic [31:0] sel_word;
  logic        wr_time_lo;
  logic        wr_time_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        tick;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req_valid_i && req_ready_o;

  // Exact word addresses only, so any misaligned address falls into the miss path.
  always_comb begin
    hit      = 1'b1;
    sel_word = '0;
    case (req_addr_i)
      32'h0000_8004: sel_word = mtime[31:0];
      32'h0000_8008: sel_word = mtime[63:32];
      32'h0000_800C: sel_word = mtimecmp[31:0];
      32'h0000_8010: sel_word = mtimecmp[63:32];
      default:       hit      = 1'b0;
    endcase
  end

  assign wr_time_lo = accept && req_we_i && (req_addr_i == 32'h0000_8004);
  assign wr_time_hi = accept && req_we_i && (req_addr_i == 32'h0000_8008);
  assign wr_cmp_lo  = accept && req_we_i && (req_addr_i == 32'h0000_800C);
  assign wr_cmp_hi  = accept && req_we_i && (req_addr_i == 32'h0000_8010);
  assign tick       = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 16'd1;
  end

  // A store to either half of mtime swallows the whole increment for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_time_lo || wr_time_hi) begin
      if (wr_time_lo) mtime[31:0]  <= req_wdata_i;
      if (wr_time_hi) mtime[63:32] <= req_wdata_i;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= req_wdata_i;
      if (wr_cmp_hi) mtimecmp[63:32] <= req_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      rdata <= (hit && !req_we_i) ? sel_word : 32'd0;
      err   <= !hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mtip <= 1'b0;
    else     mtip <= (mtime >= mtimecmp);
  end

  assign resp_rdata_o = resp_valid_o ? rdata : 32'd0;
  assign resp_err_o   = resp_valid_o && err;
  assign mtip_o       = mtip;

endmodule

// File: tb/tb_mtimer_responder.sv
// Bench for mtimer_responder: two instances (TICK_DIV 1 and 4) share stimulus and
// are checked every cycle against a register-level model plus directed literals.
module tb_mtimer_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        ready_w [2];
  logic        valid_w [2];
  logic [31:0] rdata_w [2];
  logic        err_w   [2];
  logic        mtip_w  [2];

  int compared;
  int mismatched;

  logic [63:0] m_time  [2];
  logic [63:0] m_cmp   [2];
  logic [31:0] m_rdata [2];
  logic        m_mtip  [2];
  logic        m_err;
  logic        m_busy;
  int          m_cyc;
  bit          m_live;

  logic [31:0] cap_rdata [2];
  logic        cap_err   [2];
  logic        cap_valid [2];
  logic        cap_mtip  [2];

  mtimer_responder #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(ready_w[0]), .resp_valid_o(valid_w[0]),
    .resp_rdata_o(rdata_w[0]), .resp_err_o(err_w[0]), .mtip_o(mtip_w[0])
  );

  mtimer_responder #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(ready_w[1]), .resp_valid_o(valid_w[1]),
    .resp_rdata_o(rdata_w[1]), .resp_err_o(err_w[1]), .mtip_o(mtip_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int word_idx(input logic [31:0] a);
    case (a)
      32'h0000_8004: return 0;
      32'h0000_8008: return 1;
      32'h0000_800C: return 2;
      32'h0000_8010: return 3;
      default:       return -1;
    endcase
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: mtime ticks on every edge whose count since reset is a multiple of the divisor.
  always @(posedge clk) begin : model
    int          cyc_n;
    int          idx;
    bit          acc;
    bit          bump;
    logic [63:0] t;
    logic [63:0] c;
    logic [31:0] rd;
    if (rst) begin
      m_live <= 1'b1;
      m_cyc  <= 0;
      m_busy <= 1'b0;
      m_err  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_time[i]  <= 64'd0;
        m_cmp[i]   <= '1;
        m_rdata[i] <= 32'd0;
        m_mtip[i]  <= 1'b0;
      end
    end else if (m_live) begin
      cyc_n = m_cyc + 1;
      acc   = req_valid && !m_busy;
      idx   = word_idx(req_addr);
      for (int i = 0; i < 2; i++) begin
        t    = m_time[i];
        c    = m_cmp[i];
        rd   = 32'd0;
        bump = (cyc_n % div_of(i)) == 0;
        if (acc && idx >= 0 && !req_we) begin
          case (idx)
            0:       rd = t[31:0];
            1:       rd = t[63:32];
            2:       rd = c[31:0];
            default: rd = c[63:32];
          endcase
        end
        if (acc && req_we) begin
          case (idx)
            0: begin t[31:0]  = req_wdata; bump = 1'b0; end
            1: begin t[63:32] = req_wdata; bump = 1'b0; end
            2: c[31:0]  = req_wdata;
            3: c[63:32] = req_wdata;
            default: ;
          endcase
        end
        if (bump) t = t + 64'd1;
        m_mtip[i]  <= (m_time[i] >= m_cmp[i]);
        m_time[i]  <= t;
        m_cmp[i]   <= c;
        m_rdata[i] <= rd;
      end
      m_err  <= acc && (idx < 0);
      m_busy <= acc;
      m_cyc  <= cyc_n;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("ready_d%0d", i), ready_w[i], !m_busy);
        checkOutput($sformatf("valid_d%0d", i), valid_w[i], m_busy);
        checkOutput($sformatf("rdata_d%0d", i), rdata_w[i], m_rdata[i]);
        checkOutput($sformatf("err_d%0d", i), err_w[i], m_err);
        checkOutput($sformatf("mtip_d%0d", i), mtip_w[i], m_mtip[i]);
      end
    end
  end

  // Issue one request from an idle negedge; capture the RESP cycle; return idle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int guard;
    guard = 0;
    while (!ready_w[0] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 10) checkOutput("ready_timeout", ready_w[0], 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cap_rdata[i] = rdata_w[i];
      cap_err[i]   = err_w[i];
      cap_valid[i] = valid_w[i];
      cap_mtip[i]  = mtip_w[i];
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkResp(input string name, input int d, input logic [31:0] rdata_exp,
                           input logic err_exp);
    checkOutput({name, "_valid"}, cap_valid[d], 1'b1);
    checkOutput({name, "_rdata"}, cap_rdata[d], rdata_exp);
    checkOutput({name, "_err"}, cap_err[d], err_exp);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    compared   = 0;
    mismatched = 0;
    m_live     = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    $display("[TB] start");
    doReset();

    $display("[TB] free-running count");
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 32'h8004, 32'd0);
    checkResp("idle_lo_d1", 0, 32'd10, 1'b0);
    checkResp("idle_lo_d4", 1, 32'd2, 1'b0);
    applyStimulus(1'b0, 32'h8008, 32'd0);
    checkResp("idle_hi_d1", 0, 32'd0, 1'b0);
    checkResp("idle_hi_d4", 1, 32'd0, 1'b0);

    $display("[TB] carry and wrap");
    doReset();
    applyStimulus(1'b1, 32'h8008, 32'd0);
    applyStimulus(1'b1, 32'h8004, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'h8008, 32'd0);
    checkResp("carry_hi_d1", 0, 32'd1, 1'b0);
    checkResp("carry_hi_d4", 1, 32'd1, 1'b0);
    applyStimulus(1'b0, 32'h8004, 32'd0);
    checkResp("carry_lo_d1", 0, 32'd2, 1'b0);
    checkResp("carry_lo_d4", 1, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h8008, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'h8004, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'h8004, 32'd0);
    checkResp("wrap_lo_d1", 0, 32'd0, 1'b0);
    checkResp("wrap_lo_d4", 1, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'h8008, 32'd0);
    checkResp("wrap_hi_d1", 0, 32'd0, 1'b0);
    checkResp("wrap_hi_d4", 1, 32'd0, 1'b0);

    $display("[TB] compare");
    doReset();
    applyStimulus(1'b1, 32'h8010, 32'd0);
    applyStimulus(1'b1, 32'h800C, 32'd20);
    repeat (16) @(negedge clk);
    checkOutput("cmp_mtip_before", mtip_w[0], 1'b0);
    @(negedge clk);
    checkOutput("cmp_mtip_rise", mtip_w[0], 1'b1);
    applyStimulus(1'b1, 32'h8010, 32'hFFFF_FFFF);
    checkOutput("cmp_mtip_hold", cap_mtip[0], 1'b1);
    checkOutput("cmp_mtip_drop", mtip_w[0], 1'b0);

    $display("[TB] divide by four");
    doReset();
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 32'h8004, 32'd100);
    applyStimulus(1'b0, 32'h8004, 32'd0);
    checkResp("div_rd1_d4", 1, 32'd100, 1'b0);
    checkResp("div_rd1_d1", 0, 32'd101, 1'b0);
    applyStimulus(1'b0, 32'h8004, 32'd0);
    checkResp("div_rd2_d4", 1, 32'd100, 1'b0);
    checkResp("div_rd2_d1", 0, 32'd103, 1'b0);
    applyStimulus(1'b0, 32'h8004, 32'd0);
    checkResp("div_rd3_d4", 1, 32'd101, 1'b0);
    checkResp("div_rd3_d1", 0, 32'd105, 1'b0);

    $display("[TB] errors");
    applyStimulus(1'b0, 32'h8000, 32'd0);
    checkResp("err_8000", 0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h8014, 32'd0);
    checkResp("err_8014", 1, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h8006, 32'd0);
    checkResp("err_8006", 0, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h8014, 32'h1234_5678);
    checkResp("err_st8014", 0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h800C, 32'd0);
    checkResp("cmp_lo_kept", 0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'h8010, 32'd0);
    checkResp("cmp_hi_kept", 1, 32'hFFFF_FFFF, 1'b0);

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h8004;
    pulses    = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid_w[0]) pulses++;
    end
    req_valid = 1'b0;
    checkOutput("held_valid_pulses", pulses, 3);
    @(negedge clk);

    $display("[TB] reset during response");
    applyStimulus(1'b1, 32'h8010, 32'd0);
    applyStimulus(1'b1, 32'h800C, 32'd0);
    checkOutput("pre_rst_mtip", mtip_w[0], 1'b1);
    req_valid = 1'b1;
    req_addr  = 32'h8004;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_drop_valid", valid_w[0], 1'b0);
    checkOutput("rst_mtip_d1", mtip_w[0], 1'b0);
    checkOutput("rst_mtip_d4", mtip_w[1], 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h8004, 32'd0);
    checkResp("rst_lo_d1", 0, 32'd0, 1'b0);
    checkResp("rst_lo_d4", 1, 32'd0, 1'b0);
    checkOutput("rst_cap_mtip", cap_mtip[0], 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
